// File: rtl/alu_operand_loader.sv
// alu_operand_loader: loads A, B and the op code from the switch bus on debounced button presses, then strobes the ALU.
module alu_operand_loader #(
  parameter int NB_DATA         = 4,
  parameter int NB_OPERATION    = 6,
  parameter int NB_SWITCH       = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int NB_DEBOUNCE     = 10
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NB_SWITCH-1:0]    i_switch,
  input  logic                    i_btn_a,
  input  logic                    i_btn_b,
  input  logic                    i_btn_op,
  output logic [NB_DATA-1:0]      o_data_a,
  output logic [NB_DATA-1:0]      o_data_b,
  output logic [NB_OPERATION-1:0] o_operation,
  output logic                    o_valid,
  output logic [1:0]              o_state
);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, WAIT_OP = 2'b10, ISSUE = 2'b11} state_t;
  localparam logic [NB_DEBOUNCE-1:0] CNT_MAX = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
  state_t state, next;
  logic [2:0] raw, stb;
  logic load_a, load_b, load_op;
  logic unused_switch;
  assign raw = {i_btn_op, i_btn_b, i_btn_a};
  assign unused_switch = ^i_switch;
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic sync1, sync2, deb, deb_prev;
    logic [NB_DEBOUNCE-1:0] cnt;
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        sync1    <= 1'b0;
        sync2    <= 1'b0;
        deb      <= 1'b0;
        deb_prev <= 1'b0;
        cnt      <= '0;
      end else begin
        sync1    <= raw[b];
        sync2    <= sync1;
        deb_prev <= deb;
        cnt      <= (sync2 == deb || cnt == CNT_MAX) ? '0 : cnt + NB_DEBOUNCE'(1);
        if (sync2 != deb && cnt == CNT_MAX) deb <= sync2;
      end
    end
    assign stb[b] = deb & ~deb_prev;
  end
  // Only the strobe matching the current state acts; ISSUE ignores everything.
  always_comb begin
    load_a  = state == WAIT_A && stb[0];
    load_b  = state == WAIT_B && stb[1];
    load_op = state == WAIT_OP && stb[2];
    next    = state == ISSUE ? WAIT_A :
              load_a         ? WAIT_B :
              load_b         ? WAIT_OP :
              load_op        ? ISSUE : state;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= WAIT_A;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_operation <= '0;
      o_valid     <= 1'b0;
    end else begin
      state   <= next;
      o_valid <= load_op;
      if (load_a) o_data_a <= i_switch[NB_DATA-1:0];
      if (load_b) o_data_b <= i_switch[NB_DATA-1:0];
      if (load_op) o_operation <= i_switch[NB_OPERATION-1:0];
    end
  end
  assign o_state = state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: table-driven sequences plus corner cases; a scoreboard checks every o_valid pulse.
module tb_alu_operand_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_a, btn_b, btn_op;
  logic [3:0] data_a, data_b;
  logic [5:0] operation;
  logic       valid;
  logic [1:0] state;

  typedef struct {
    logic [7:0] sw_a, sw_b, sw_op;
    logic [3:0] a, b;
    logic [5:0] op;
  } vec_t;
  typedef struct packed {
    logic [3:0] a, b;
    logic [5:0] op;
  } exp_t;

  int   total = 0, passed = 0, valids = 0, expected_valids = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[3];

  alu_operand_loader #(
    .NB_DATA(4), .NB_OPERATION(6), .NB_SWITCH(8), .DEBOUNCE_CYCLES(4), .NB_DEBOUNCE(10)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_switch(sw),
    .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
    .o_data_a(data_a), .o_data_b(data_b), .o_operation(operation),
    .o_valid(valid), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      valids++;
      check("valid_expected", 32'(sb.size() > 0), 1);
      check("valid_state", state, 2'b11);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("issue_a", data_a, mon_e.a);
        check("issue_b", data_b, mon_e.b);
        check("issue_op", operation, mon_e.op);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int i, input logic v);
    case (i)
      0:       btn_a = v;
      1:       btn_b = v;
      default: btn_op = v;
    endcase
  endtask

  task automatic press(input int i, input logic [7:0] s, input int hold);
    sw = s;
    set_btn(i, 1'b1);
    tick(hold);
    set_btn(i, 1'b0);
    tick(10);
  endtask

  // First sampling edge is the next rising edge; the load must land exactly 6 edges later.
  task automatic press_timed(input int i, input logic [7:0] s, input logic [1:0] st0, input logic [1:0] st1);
    sw = s;
    set_btn(i, 1'b1);
    tick(6);
    check("pre_load_state", state, st0);
    tick(1);
    check("load_edge_state", state, st1);
    check("load_edge_valid", valid, 32'(st1 == 2'b11));
    tick(3);
    set_btn(i, 1'b0);
    tick(10);
  endtask

  task automatic full_seq(input vec_t v);
    press_timed(0, v.sw_a, 2'b00, 2'b01);
    check("seq_a", data_a, v.a);
    press_timed(1, v.sw_b, 2'b01, 2'b10);
    check("seq_b", data_b, v.b);
    sb.push_back('{a: v.a, b: v.b, op: v.op});
    expected_valids++;
    press_timed(2, v.sw_op, 2'b10, 2'b11);
    check("seq_state_back", state, 2'b00);
    check("seq_op", operation, v.op);
    check("seq_a_hold", data_a, v.a);
    check("seq_b_hold", data_b, v.b);
  endtask

  initial begin
    vecs[0] = '{sw_a: 8'h05, sw_b: 8'h03, sw_op: 8'h20, a: 4'h5, b: 4'h3, op: 6'b100000};
    vecs[1] = '{sw_a: 8'hFA, sw_b: 8'h9C, sw_op: 8'hC7, a: 4'hA, b: 4'hC, op: 6'h07};
    vecs[2] = '{sw_a: 8'h0F, sw_b: 8'hF0, sw_op: 8'h3F, a: 4'hF, b: 4'h0, op: 6'h3F};
    rst = 1'b1; sw = 8'h00; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_a", data_a, 0);
    check("rst_b", data_b, 0);
    check("rst_op", operation, 0);
    check("rst_valid", valid, 0);
    check("rst_state", state, 2'b00);
    tick(20);
    check("idle_state", state, 2'b00);
    check("idle_a", data_a, 0);
    check("idle_valid", valid, 0);

    for (int i = 0; i < 3; i++) full_seq(vecs[i]);

    // glitch of 3 samples must be rejected, a 4-cycle press accepted
    sw = 8'h06;
    btn_a = 1'b1;
    tick(3);
    btn_a = 1'b0;
    tick(10);
    check("glitch_state", state, 2'b00);
    check("glitch_a", data_a, 4'hF);
    press(0, 8'h06, 4);
    check("short_press_state", state, 2'b01);
    check("short_press_a", data_a, 4'h6);
    press(1, 8'h02, 10);
    sb.push_back('{a: 4'h6, b: 4'h2, op: 6'h15});
    expected_valids++;
    press(2, 8'h15, 10);
    check("glitch_seq_state", state, 2'b00);
    check("glitch_seq_op", operation, 6'h15);

    // out-of-order presses in WAIT_A, then a long hold
    press(2, 8'h3F, 10);
    press(1, 8'h0C, 10);
    check("ooo_state", state, 2'b00);
    check("ooo_b", data_b, 4'h2);
    check("ooo_op", operation, 6'h15);
    sw = 8'h09;
    btn_a = 1'b1;
    tick(50);
    check("hold_state", state, 2'b01);
    check("hold_a", data_a, 4'h9);
    btn_a = 1'b0;
    tick(10);
    check("hold_release_state", state, 2'b01);
    press(1, 8'h07, 10);
    check("wait_op_state", state, 2'b10);
    check("wait_op_b", data_b, 4'h7);

    // reset during an OP press; the still-held button must not issue
    sw = 8'h2A;
    btn_op = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("midrst_state", state, 2'b00);
    check("midrst_a", data_a, 0);
    check("midrst_b", data_b, 0);
    check("midrst_op", operation, 0);
    tick(20);
    check("midrst_held_state", state, 2'b00);
    check("midrst_held_op", operation, 0);
    btn_op = 1'b0;
    tick(10);
    press(2, 8'h11, 10);
    check("midrst_repress_state", state, 2'b00);
    check("midrst_repress_op", operation, 0);

    full_seq(vecs[1]);

    tick(5);
    check("sb_empty", sb.size(), 0);
    check("valid_count", valids, expected_valids);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
